// File: rtl/lc3_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lc3_ctrl_pkg
// Shared definitions for the LC-3 control sequencer: opcode constants, mux
// select encodings, the sequencer state type, the bundled control-word struct
// and the DECODE dispatch function.
//
// Configuration macro: LC3_PAUSE_EN adds the PAUSE1/PAUSE2 states and makes
// opcode 1101 dispatch to them; without it 1101 is a no-op.
// -----------------------------------------------------------------------------
package lc3_ctrl_pkg;

   // Opcodes as seen in IR[15:12]
   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   // PC input mux
   localparam logic [1:0] PCMUX_BUS   = 2'b00;
   localparam logic [1:0] PCMUX_ADDER = 2'b01;
   localparam logic [1:0] PCMUX_PC1   = 2'b10;

   // Second address-adder operand
   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;

   // ALU function
   localparam logic [1:0] ALUK_ADD   = 2'b00;
   localparam logic [1:0] ALUK_AND   = 2'b01;
   localparam logic [1:0] ALUK_NOT   = 2'b10;
   localparam logic [1:0] ALUK_PASSA = 2'b11;

   typedef enum logic [4:0] {
      S_HALTED,
      S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
      S_ADD, S_AND, S_NOT,
      S_BR0, S_BR1,
      S_JMP,
      S_JSR0, S_JSR1,
      S_LDR0, S_LDR1, S_LDR2,
      S_STR0, S_STR1, S_STR2
`ifdef LC3_PAUSE_EN
      , S_PAUSE1, S_PAUSE2
`endif
   } state_t;

   // One bit/field per datapath control line; all-zero is the idle word
   typedef struct packed {
      logic       ld_pc;
      logic       ld_ir;
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_reg;
      logic       ld_cc;
      logic       ld_ben;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       addr1mux;
      logic       drmux;
      logic       sr1mux;
      logic       mio_en;
      logic       mem_oe;
      logic       mem_we;
      logic       halted;
   } ctrl_t;

   // DECODE dispatch; unknown opcodes fall back to a fresh fetch
   function automatic state_t decode_op(input logic [3:0] op);
      state_t nxt;
      unique case (op)
         OP_ADD:   nxt = S_ADD;
         OP_AND:   nxt = S_AND;
         OP_NOT:   nxt = S_NOT;
         OP_BR:    nxt = S_BR0;
         OP_JMP:   nxt = S_JMP;
         OP_JSR:   nxt = S_JSR0;
         OP_LDR:   nxt = S_LDR0;
         OP_STR:   nxt = S_STR0;
`ifdef LC3_PAUSE_EN
         OP_PAUSE: nxt = S_PAUSE1;
`endif
         default:  nxt = S_FETCH1;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/lc3_control_fsm_mem_wait_ctr.sv
// -----------------------------------------------------------------------------
// mem_wait_ctr
// Memory wait counter shared by every memory-access state. While en_i is high
// it counts up each cycle; done_o flags the last cycle of the access
// (count == MEM_WAIT), after which the count returns to zero. Outside memory
// states the count is held at zero.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset (count -> 0)
//   en_i    high while the sequencer sits in a memory-access state
//   done_o  high on the final cycle of the access
// -----------------------------------------------------------------------------
module mem_wait_ctr #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic done_o
);

   localparam logic [2:0] LAST = 3'(MEM_WAIT);

   logic [2:0] cnt_q;
   logic [2:0] cnt_d;

   assign done_o = (cnt_q == LAST);

   // Clearing on done means back-to-back memory states start from zero
   always_comb begin
      cnt_d = '0;
      if (en_i && !done_o) begin
         cnt_d = cnt_q + 3'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lc3_control_fsm.sv
// -----------------------------------------------------------------------------
// lc3_control_fsm
// Moore-style control sequencer for the LC-3 datapath. Runs fetch / decode /
// execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and (optionally) PAUSE,
// driving every load strobe, bus gate, mux select and memory enable.
//
// Configuration macro: LC3_PAUSE_EN (adds PAUSE1/PAUSE2 for opcode 1101).
//
// Parameter:
//   MEM_WAIT    extra wait cycles per memory access (0..7); each memory state
//               lasts MEM_WAIT+1 cycles
// Ports:
//   Clk, Reset_ah              clock / asynchronous active-high reset
//   Run, Continue              start from HALTED / resume from PAUSE
//   IR_op[4:0], BEN            IR[15:11] and branch-enable from the datapath
//   LD_*                       register load strobes
//   Gate*                      bus drivers (at most one high)
//   PCMUX, ADDR2MUX, ALUK,
//   ADDR1MUX, DRMUX, SR1MUX    datapath mux selects
//   MIO_EN, Mem_OE, Mem_WE     MDR source select and memory enables
//   Halted                     high in HALTED
// -----------------------------------------------------------------------------
module lc3_control_fsm
   import lc3_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       Clk,
   input  logic       Reset_ah,
   input  logic       Run,
   input  logic       Continue,
   input  logic [4:0] IR_op,
   input  logic       BEN,
   output logic       LD_PC,
   output logic       LD_IR,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_REG,
   output logic       LD_CC,
   output logic       LD_BEN,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       ADDR1MUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       MIO_EN,
   output logic       Mem_OE,
   output logic       Mem_WE,
   output logic       Halted
);

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;
   logic   wait_en;
   logic   wait_done;

   // IR[11] would select JSRR, which is not supported
`ifdef LC3_PAUSE_EN
   logic unused_inputs;
   assign unused_inputs = IR_op[0];
`else
   logic unused_inputs;
   assign unused_inputs = IR_op[0] ^ Continue;
`endif

   assign wait_en = (state_q == S_FETCH2) || (state_q == S_LDR1) || (state_q == S_STR2);

   mem_wait_ctr #(
      .MEM_WAIT (MEM_WAIT)
   ) u_wait (
      .clk_i  (Clk),
      .rst_i  (Reset_ah),
      .en_i   (wait_en),
      .done_o (wait_done)
   );

   // State register
   always_ff @(posedge Clk or posedge Reset_ah) begin
      if (Reset_ah) begin
         state_q <= S_HALTED;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   // NOTE: every variable assigned in an always_comb gets a default first,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_HALTED: if (Run) state_d = S_FETCH1;
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: if (wait_done) state_d = S_FETCH3;
         S_FETCH3: state_d = S_DECODE;
         S_DECODE: state_d = decode_op(IR_op[4:1]);
         S_ADD,
         S_AND,
         S_NOT,
         S_BR1,
         S_JMP,
         S_JSR1,
         S_LDR2:   state_d = S_FETCH1;
         S_BR0:    state_d = BEN ? S_BR1 : S_FETCH1;
         S_JSR0:   state_d = S_JSR1;
         S_LDR0:   state_d = S_LDR1;
         S_LDR1:   if (wait_done) state_d = S_LDR2;
         S_STR0:   state_d = S_STR1;
         S_STR1:   state_d = S_STR2;
         S_STR2:   if (wait_done) state_d = S_FETCH1;
`ifdef LC3_PAUSE_EN
         // Press-and-release handshake: one instruction per button press
         S_PAUSE1: if (Continue)  state_d = S_PAUSE2;
         S_PAUSE2: if (!Continue) state_d = S_FETCH1;
`endif
         default:  state_d = S_HALTED;
      endcase
   end

   // Output decode (from state, plus the counter for the MDR load strobe)
   always_comb begin
      ctrl = '0;
      unique case (state_q)
         S_HALTED: ctrl.halted = 1'b1;
         S_FETCH1: begin
            ctrl.gate_pc = 1'b1;
            ctrl.ld_mar  = 1'b1;
            ctrl.ld_pc   = 1'b1;
            ctrl.pcmux   = PCMUX_PC1;
         end
         S_FETCH2,
         S_LDR1: begin
            ctrl.mem_oe = 1'b1;
            ctrl.mio_en = 1'b1;
            // Capture the read data only once the access has settled
            ctrl.ld_mdr = wait_done;
         end
         S_FETCH3: begin
            ctrl.gate_mdr = 1'b1;
            ctrl.ld_ir    = 1'b1;
         end
         S_DECODE: ctrl.ld_ben = 1'b1;
         S_ADD,
         S_AND,
         S_NOT: begin
            ctrl.sr1mux   = 1'b1;
            ctrl.gate_alu = 1'b1;
            ctrl.ld_reg   = 1'b1;
            ctrl.ld_cc    = 1'b1;
            ctrl.aluk     = (state_q == S_ADD) ? ALUK_ADD :
                            (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
         end
         S_BR1: begin
            ctrl.addr2mux = ADDR2_OFF9;
            ctrl.pcmux    = PCMUX_ADDER;
            ctrl.ld_pc    = 1'b1;
         end
         S_JMP: begin
            ctrl.sr1mux   = 1'b1;
            ctrl.addr1mux = 1'b1;
            ctrl.addr2mux = ADDR2_ZERO;
            ctrl.pcmux    = PCMUX_ADDER;
            ctrl.ld_pc    = 1'b1;
         end
         S_JSR0: begin
            ctrl.gate_pc = 1'b1;
            ctrl.drmux   = 1'b1;
            ctrl.ld_reg  = 1'b1;
         end
         S_JSR1: begin
            ctrl.addr2mux = ADDR2_OFF11;
            ctrl.pcmux    = PCMUX_ADDER;
            ctrl.ld_pc    = 1'b1;
         end
         S_LDR0,
         S_STR0: begin
            ctrl.sr1mux      = 1'b1;
            ctrl.addr1mux    = 1'b1;
            ctrl.addr2mux    = ADDR2_OFF6;
            ctrl.gate_marmux = 1'b1;
            ctrl.ld_mar      = 1'b1;
         end
         S_LDR2: begin
            ctrl.gate_mdr = 1'b1;
            ctrl.ld_reg   = 1'b1;
            ctrl.ld_cc    = 1'b1;
         end
         S_STR1: begin
            // Source register (IR[11:9]) passes through the ALU into MDR
            ctrl.aluk     = ALUK_PASSA;
            ctrl.gate_alu = 1'b1;
            ctrl.ld_mdr   = 1'b1;
         end
         S_STR2:  ctrl.mem_we = 1'b1;
         default: ctrl = '0;
      endcase
   end

   assign LD_PC      = ctrl.ld_pc;
   assign LD_IR      = ctrl.ld_ir;
   assign LD_MAR     = ctrl.ld_mar;
   assign LD_MDR     = ctrl.ld_mdr;
   assign LD_REG     = ctrl.ld_reg;
   assign LD_CC      = ctrl.ld_cc;
   assign LD_BEN     = ctrl.ld_ben;
   assign GatePC     = ctrl.gate_pc;
   assign GateMDR    = ctrl.gate_mdr;
   assign GateALU    = ctrl.gate_alu;
   assign GateMARMUX = ctrl.gate_marmux;
   assign PCMUX      = ctrl.pcmux;
   assign ADDR2MUX   = ctrl.addr2mux;
   assign ALUK       = ctrl.aluk;
   assign ADDR1MUX   = ctrl.addr1mux;
   assign DRMUX      = ctrl.drmux;
   assign SR1MUX     = ctrl.sr1mux;
   assign MIO_EN     = ctrl.mio_en;
   assign Mem_OE     = ctrl.mem_oe;
   assign Mem_WE     = ctrl.mem_we;
   assign Halted     = ctrl.halted;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_lc3_control_fsm
// Two sequencer instances: index 0 with MEM_WAIT=1, index 1 with MEM_WAIT=3.
// The stimulus process drives one instance at a time and, for every cycle,
// queues the hand-written control word expected in that cycle. A monitor pops
// the queue on each falling edge and compares against the selected instance.
// -----------------------------------------------------------------------------
module tb_lc3_control_fsm;

   typedef struct packed {
      logic       ld_pc;
      logic       ld_ir;
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_reg;
      logic       ld_cc;
      logic       ld_ben;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       addr1mux;
      logic       drmux;
      logic       sr1mux;
      logic       mio_en;
      logic       mem_oe;
      logic       mem_we;
      logic       halted;
   } vec_t;

   typedef enum {
      E_HALTED, E_FETCH1, E_MEMRD, E_MEMRD_LAST, E_FETCH3, E_DECODE,
      E_ADD, E_AND, E_NOT, E_IDLE, E_BR1, E_JMP, E_JSR0, E_JSR1,
      E_ADDRCALC, E_LDR2, E_STR1, E_STR2
   } exp_e;

   typedef struct {
      int   d;
      exp_e s;
      vec_t v;
   } sb_t;

   logic       clk;
   logic       rst_v   [2];
   logic       run_v   [2];
   logic       cont_v  [2];
   logic       ben_v   [2];
   logic [4:0] irop_v  [2];
   vec_t       obs     [2];

   sb_t sb[$];
   int  checks = 0;
   int  errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic       ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben;
      logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
      logic [1:0] pcmux, addr2mux, aluk;
      logic       addr1mux, drmux, sr1mux, mio_en, mem_oe, mem_we, halted;

      lc3_control_fsm #(
         .MEM_WAIT (g == 0 ? 1 : 3)
      ) u_dut (
         .Clk        (clk),
         .Reset_ah   (rst_v[g]),
         .Run        (run_v[g]),
         .Continue   (cont_v[g]),
         .IR_op      (irop_v[g]),
         .BEN        (ben_v[g]),
         .LD_PC      (ld_pc),
         .LD_IR      (ld_ir),
         .LD_MAR     (ld_mar),
         .LD_MDR     (ld_mdr),
         .LD_REG     (ld_reg),
         .LD_CC      (ld_cc),
         .LD_BEN     (ld_ben),
         .GatePC     (gate_pc),
         .GateMDR    (gate_mdr),
         .GateALU    (gate_alu),
         .GateMARMUX (gate_marmux),
         .PCMUX      (pcmux),
         .ADDR2MUX   (addr2mux),
         .ALUK       (aluk),
         .ADDR1MUX   (addr1mux),
         .DRMUX      (drmux),
         .SR1MUX     (sr1mux),
         .MIO_EN     (mio_en),
         .Mem_OE     (mem_oe),
         .Mem_WE     (mem_we),
         .Halted     (halted)
      );

      assign obs[g] = {ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben,
                       gate_pc, gate_mdr, gate_alu, gate_marmux,
                       pcmux, addr2mux, aluk,
                       addr1mux, drmux, sr1mux, mio_en, mem_oe, mem_we, halted};
   end

   // Expected control word for each state class, written out from the table
   function automatic vec_t ev(input exp_e s);
      vec_t v;
      v = '0;
      case (s)
         E_HALTED:     v.halted = 1'b1;
         E_FETCH1:     begin v.gate_pc = 1; v.ld_mar = 1; v.ld_pc = 1; v.pcmux = 2'b10; end
         E_MEMRD:      begin v.mem_oe = 1; v.mio_en = 1; end
         E_MEMRD_LAST: begin v.mem_oe = 1; v.mio_en = 1; v.ld_mdr = 1; end
         E_FETCH3:     begin v.gate_mdr = 1; v.ld_ir = 1; end
         E_DECODE:     v.ld_ben = 1'b1;
         E_ADD:        begin v.sr1mux = 1; v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1; v.aluk = 2'b00; end
         E_AND:        begin v.sr1mux = 1; v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1; v.aluk = 2'b01; end
         E_NOT:        begin v.sr1mux = 1; v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1; v.aluk = 2'b10; end
         E_IDLE:       v = '0;
         E_BR1:        begin v.addr2mux = 2'b10; v.pcmux = 2'b01; v.ld_pc = 1; end
         E_JMP:        begin v.sr1mux = 1; v.addr1mux = 1; v.pcmux = 2'b01; v.ld_pc = 1; end
         E_JSR0:       begin v.gate_pc = 1; v.drmux = 1; v.ld_reg = 1; end
         E_JSR1:       begin v.addr2mux = 2'b11; v.pcmux = 2'b01; v.ld_pc = 1; end
         E_ADDRCALC:   begin v.sr1mux = 1; v.addr1mux = 1; v.addr2mux = 2'b01;
                             v.gate_marmux = 1; v.ld_mar = 1; end
         E_LDR2:       begin v.gate_mdr = 1; v.ld_reg = 1; v.ld_cc = 1; end
         E_STR1:       begin v.aluk = 2'b11; v.gate_alu = 1; v.ld_mdr = 1; end
         E_STR2:       v.mem_we = 1'b1;
         default:      v = '0;
      endcase
      return v;
   endfunction

   // Monitor: one queued expectation per cycle, compared mid-cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         sb_t e;
         e = sb.pop_front();
         checks++;
         if (obs[e.d] !== e.v) begin
            errors++;
            $display("FAIL dut%0d %s: got %h expected %h", e.d, e.s.name(), obs[e.d], e.v);
         end
      end
   end

   // Queue the expectation for the current cycle, then advance one cycle
   task automatic cyc(input int d, input exp_e s);
      sb_t e;
      e.d = d;
      e.s = s;
      e.v = ev(s);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int d, input int mw, input logic [4:0] op);
      irop_v[d] = op;
      cyc(d, E_FETCH1);
      for (int i = 0; i < mw; i++) cyc(d, E_MEMRD);
      cyc(d, E_MEMRD_LAST);
      cyc(d, E_FETCH3);
      cyc(d, E_DECODE);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_v[i]  = 1'b1;
         run_v[i]  = 1'b0;
         cont_v[i] = 1'b0;
         ben_v[i]  = 1'b0;
         irop_v[i] = 5'b0;
      end
      @(posedge clk);
      #1;

      // ---------------- instance 0, MEM_WAIT=1 ----------------
      cyc(0, E_HALTED);                 // held in reset
      rst_v[0] = 1'b0;
      cyc(0, E_HALTED);
      cyc(0, E_HALTED);
      run_v[0] = 1'b1;
      cyc(0, E_HALTED);                 // Run sampled here
      // Run left high through ADD: must be ignored outside HALTED
      fetch(0, 1, 5'b00010);
      cyc(0, E_ADD);
      run_v[0] = 1'b0;
      fetch(0, 1, 5'b01010);
      cyc(0, E_AND);
      fetch(0, 1, 5'b10011);
      cyc(0, E_NOT);
      ben_v[0] = 1'b0;
      fetch(0, 1, 5'b00000);
      cyc(0, E_IDLE);                   // BR0, not taken
      ben_v[0] = 1'b1;
      fetch(0, 1, 5'b00001);
      cyc(0, E_IDLE);                   // BR0, taken
      cyc(0, E_BR1);
      ben_v[0] = 1'b0;
      fetch(0, 1, 5'b11000);
      cyc(0, E_JMP);
      fetch(0, 1, 5'b01001);
      cyc(0, E_JSR0);
      cyc(0, E_JSR1);
      fetch(0, 1, 5'b01100);
      cyc(0, E_ADDRCALC);
      cyc(0, E_MEMRD);
      cyc(0, E_MEMRD_LAST);
      cyc(0, E_LDR2);
      fetch(0, 1, 5'b01110);
      cyc(0, E_ADDRCALC);
      cyc(0, E_STR1);
      cyc(0, E_STR2);
      cyc(0, E_STR2);
      fetch(0, 1, 5'b10100);            // undefined opcode: straight back to fetch
      fetch(0, 1, 5'b11010);            // PAUSE opcode
`ifdef LC3_PAUSE_EN
      cont_v[0] = 1'b0;
      for (int i = 0; i < 10; i++) cyc(0, E_IDLE);
      cont_v[0] = 1'b1;
      cyc(0, E_IDLE);                   // PAUSE1 sees press
      cyc(0, E_IDLE);                   // PAUSE2 waits for release
      cont_v[0] = 1'b0;
      cyc(0, E_IDLE);                   // PAUSE2 sees release
`endif
      fetch(0, 1, 5'b00010);
      cyc(0, E_ADD);
      cyc(0, E_FETCH1);
      rst_v[0] = 1'b1;

      // ---------------- instance 1, MEM_WAIT=3 ----------------
      cyc(1, E_HALTED);
      rst_v[1] = 1'b0;
      run_v[1] = 1'b1;
      cyc(1, E_HALTED);
      run_v[1] = 1'b0;
      fetch(1, 3, 5'b01110);
      cyc(1, E_ADDRCALC);
      cyc(1, E_STR1);
      for (int i = 0; i < 4; i++) cyc(1, E_STR2);
      fetch(1, 3, 5'b01111);
      cyc(1, E_ADDRCALC);
      cyc(1, E_STR1);
      cyc(1, E_STR2);
      cyc(1, E_STR2);
      rst_v[1] = 1'b1;                  // asynchronous reset mid-store
      cyc(1, E_HALTED);
      rst_v[1] = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1, E_HALTED);
      run_v[1] = 1'b1;
      cyc(1, E_HALTED);
      run_v[1] = 1'b0;
      fetch(1, 3, 5'b00010);            // wait count must restart from zero
      cyc(1, E_ADD);
      cyc(1, E_FETCH1);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
